// File: rtl/collect_sched.sv
// collect_sched: request/reply sequencer for the collect board USB link.
// Catches a host bag (fs_read_i/read_btype_i), acks it with fd_read_o, decodes
// the bag type and, after a prep interval (plus data readiness for DATA bags),
// issues a send (fs_send_o/send_btype_o) and waits for fd_send_i.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   fs_read_i            host bag received (level, held until fd_read_o)
//   read_btype_i[3:0]    received bag type, valid with fs_read_i
//   fd_read_o            read-side ack
//   data_rdy_i           acquisition frame ready in RAM
//   fs_send_o            start send, held until fd_send_i
//   send_btype_o[3:0]    bag type to send
//   fd_send_i            send complete
//   link_o               host link established
//   err_cnt_o[7:0]       saturating count of rejected/aborted requests
//   busy_o               high whenever not idling in WAIT
module collect_sched #(
  parameter logic [15:0] CNUM = 16'h0030,
  parameter logic [15:0] DNUM = 16'h0050,
  parameter logic [15:0] TOUT = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       fs_read_i,
  input  logic [3:0] read_btype_i,
  output logic       fd_read_o,
  input  logic       data_rdy_i,
  output logic       fs_send_o,
  output logic [3:0] send_btype_o,
  input  logic       fd_send_i,
  output logic       link_o,
  output logic [7:0] err_cnt_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT = 4'd1, GAP  = 4'd2, WORK = 4'd3,
    LINK = 4'd4, CONF = 4'd5, TEMP = 4'd6, DATA = 4'd7,
    PREP = 4'd8, SEND = 4'd9, ABRT = 4'd10
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  btype_q, btype_d;
  logic [15:0] num_q, num_d;
  logic [15:0] lim_q, lim_d;
  logic        need_q, need_d;
  logic        link_q, link_d;
  logic [3:0]  sbt_q, sbt_d;
  logic [7:0]  err_q, err_d;
  logic        err_inc;

  // state and datapath registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      btype_q <= 4'h0;
      num_q   <= 16'h0;
      lim_q   <= 16'h0;
      need_q  <= 1'b0;
      link_q  <= 1'b0;
      sbt_q   <= 4'h0;
      err_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      btype_q <= btype_d;
      num_q   <= num_d;
      lim_q   <= lim_d;
      need_q  <= need_d;
      link_q  <= link_d;
      sbt_q   <= sbt_d;
      err_q   <= err_d;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    btype_d = btype_q;
    num_d   = 16'h0;             // num only runs in PREP/SEND
    lim_d   = lim_q;
    need_d  = need_q;
    link_d  = link_q;
    sbt_d   = sbt_q;
    err_inc = 1'b0;
    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: if (fs_read_i) begin
        state_d = GAP;
        btype_d = read_btype_i;
      end
      GAP:  if (!fs_read_i) state_d = WORK;
      WORK: begin
        if (btype_q == 4'h8) state_d = LINK;
        else if (!link_q) begin
          state_d = WAIT;
          err_inc = 1'b1;
        end else begin
          case (btype_q)
            4'h9:       state_d = CONF;
            4'hA:       state_d = TEMP;
            4'hD, 4'hE: state_d = DATA;
            default: begin
              state_d = WAIT;
              err_inc = 1'b1;
            end
          endcase
        end
      end
      LINK: begin
        link_d = 1'b1; sbt_d = 4'h5; lim_d = CNUM; need_d = 1'b0; state_d = PREP;
      end
      CONF: begin
        sbt_d = 4'h6; lim_d = CNUM; need_d = 1'b0; state_d = PREP;
      end
      TEMP: begin
        sbt_d = 4'h7; lim_d = DNUM; need_d = 1'b0; state_d = PREP;
      end
      DATA: begin
        sbt_d = 4'h7; lim_d = DNUM; need_d = 1'b1; state_d = PREP;
      end
      PREP: begin
        num_d = num_q + 16'd1;
        // ready-to-send takes priority over timeout in the same cycle
        if (num_q >= lim_q - 16'd1 && (!need_q || data_rdy_i)) begin
          state_d = SEND;
          num_d   = 16'h0;
        end else if (num_q == TOUT - 16'd1) state_d = ABRT;
      end
      SEND: begin
        num_d = num_q + 16'd1;
        // completion takes priority over timeout in the same cycle
        if (fd_send_i) state_d = WAIT;
        else if (num_q == TOUT - 16'd1) state_d = ABRT;
      end
      ABRT: begin
        err_inc = 1'b1;
        state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // outputs: plain decodes of the state register and datapath regs
  always_comb begin
    fd_read_o    = (state_q == GAP);
    fs_send_o    = (state_q == SEND);
    busy_o       = (state_q != WAIT);
    send_btype_o = sbt_q;
    link_o       = link_q;
    err_cnt_o    = err_q;
  end

endmodule

// File: tb/tb_collect_sched.sv
module tb_collect_sched;
  logic       clk = 1'b0;
  logic       rst_n, fs_read, data_rdy, fd_send;
  logic [3:0] read_btype;
  logic       fd_read, fs_send, link, busy;
  logic [3:0] send_btype;
  logic [7:0] err_cnt;
  int         n_cmp = 0, n_err = 0;

  collect_sched #(.CNUM(16'h0030), .DNUM(16'h0050), .TOUT(16'h0100)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fs_read_i(fs_read), .read_btype_i(read_btype),
    .fd_read_o(fd_read), .data_rdy_i(data_rdy), .fs_send_o(fs_send),
    .send_btype_o(send_btype), .fd_send_i(fd_send), .link_o(link),
    .err_cnt_o(err_cnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // issue one host request; returns with the DUT sitting in WORK
  task automatic req(input logic [3:0] bt);
    fs_read = 1'b1; read_btype = bt;
    tick();
    fs_read = 1'b0;
    tick();
  endtask

  // count cycles until fs_send rises (bounded)
  task automatic wait_send(input int maxc, output int n);
    n = 0;
    while (!fs_send && n < maxc) begin tick(); n++; end
  endtask

  initial begin
    int n, hi;
    logic seen;
    rst_n = 1'b0; fs_read = 1'b0; read_btype = 4'h0; data_rdy = 1'b0; fd_send = 1'b0;
    tick(); tick();
    chk("rst_fd_read", fd_read, 0);
    chk("rst_fs_send", fs_send, 0);
    chk("rst_btype", send_btype, 0);
    chk("rst_link", link, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_busy_idle", busy, 1);
    rst_n = 1'b1;
    tick();
    chk("wait_busy", busy, 0);

    // unlinked DTYPE is rejected
    req(4'h9);
    chk("unl_fs_send", fs_send, 0);
    tick();
    chk("unl_err", err_cnt, 1);
    chk("unl_wait", busy, 0);

    // link request, fs_read held 3 cycles
    fs_read = 1'b1; read_btype = 4'h8;
    tick(); chk("lnk_fd_read1", fd_read, 1);
    tick(); tick(); chk("lnk_fd_read3", fd_read, 1);
    fs_read = 1'b0;
    tick(); chk("lnk_fd_read_drop", fd_read, 0);
    wait_send(200, n);
    chk("lnk_latency", n, 32'h32);
    chk("lnk_btype", send_btype, 5);
    chk("lnk_link", link, 1);
    fd_send = 1'b1; tick(); fd_send = 1'b0;
    chk("lnk_done_fs", fs_send, 0);
    chk("lnk_done_wait", busy, 0);

    // DATA0 gated by data_rdy, released at PREP cycle 0x80
    req(4'hD);
    tick(); tick();              // DATA, then PREP with num=0
    seen = 1'b0;
    repeat (16'h80) begin tick(); if (fs_send) seen = 1'b1; end
    chk("dat_no_early_send", seen, 0);
    data_rdy = 1'b1;
    tick();
    chk("dat_send", fs_send, 1);
    chk("dat_btype", send_btype, 7);
    fd_send = 1'b1; tick(); fd_send = 1'b0; data_rdy = 1'b0;
    chk("dat_wait", busy, 0);

    // DATA1 with data never ready -> abort
    req(4'hE);
    n = 0; seen = 1'b0;
    while (busy && n < 600) begin tick(); n++; if (fs_send) seen = 1'b1; end
    chk("dab_cycles", n, 32'h103);
    chk("dab_no_send", seen, 0);
    chk("dab_err", err_cnt, 2);

    // SEND timeout with fd_send low
    req(4'h9);
    wait_send(200, n);
    chk("sto_latency", n, 32'h32);
    chk("sto_btype", send_btype, 6);
    hi = 1;
    while (fs_send && hi < 600) begin tick(); if (fs_send) hi++; end
    chk("sto_hi_cycles", hi, 32'h100);
    chk("sto_abrt_busy", busy, 1);
    tick();
    chk("sto_err", err_cnt, 3);
    chk("sto_wait", busy, 0);

    // fd_send on the timeout cycle wins
    req(4'h9);
    wait_send(200, n);
    repeat (16'hFF) tick();
    chk("stw_still_send", fs_send, 1);
    fd_send = 1'b1; tick(); fd_send = 1'b0;
    chk("stw_wait", busy, 0);
    chk("stw_err", err_cnt, 3);

    // unknown type while linked; saturation
    req(4'h3);
    tick();
    chk("unk_err", err_cnt, 4);
    for (int i = 0; i < 300; i++) begin
      req(4'h3); tick();
      if (i == 249) chk("sat_254", err_cnt, 8'hFE);
    end
    chk("sat_ff", err_cnt, 8'hFF);

    // reset during SEND
    req(4'h9);
    wait_send(200, n);
    chk("rsd_in_send", fs_send, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rsd_fs_send", fs_send, 0);
    chk("rsd_fd_read", fd_read, 0);
    chk("rsd_link", link, 0);
    chk("rsd_err", err_cnt, 0);
    chk("rsd_btype", send_btype, 0);
    chk("rsd_idle", busy, 1);
    tick();
    chk("rsd_wait", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
